// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Types and constants shared by the refill arbiter and the
//               I/D cache controllers: refill FSM states, requester IDs,
//               default block size and the derived word-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Words per cache block. Must be a power of two and at least 2.
    localparam int BLK_WORDS_DEFAULT = 4;
    localparam int CNT_W_DEFAULT     = $clog2(BLK_WORDS_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } refill_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/block_burst_counter.sv
`default_nettype none
// ============================================================================
// Module      : block_burst_counter
// Description : Word counter for one block burst. Counts accepted words and
//               flags the final word of the block. Usable by the cache
//               controllers as their own end-of-block source.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               clear       - return count to word 0 (start of a new block)
//               enable      - one word accepted this cycle
//               cnt         - current word index within the block
//               last        - cnt is the final word of the block
// Revision    : 1.0 - initial release
// ============================================================================
module block_burst_counter
    import cache_pkg::*;
#(
    parameter int BLK_WORDS = BLK_WORDS_DEFAULT,
    parameter int CNT_W     = $clog2(BLK_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Clear takes priority over enable so a new block always starts at 0.
    // The count wraps naturally at BLK_WORDS.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(BLK_WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : refill_arbiter
// Description : Shares the main-memory read port between the I-cache and
//               D-cache refill paths. Round-robin grant, fixed-length word
//               burst, words returned to the owner, one-cycle done pulse.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               i_req/i_addr         - I-cache refill request and miss address
//               d_req/d_addr         - D-cache refill request and miss address
//               i_grant/d_grant      - owner of the current burst
//               i_wvalid/d_wvalid    - rdata/word_idx carries a word for owner
//               i_done/d_done        - end-of-block pulse
//               rdata/word_idx       - registered refill word and its index
//               mem_rd/mem_addr      - memory read strobe and word address
//               mem_ready/mem_rdata  - memory accept and read data
// Revision    : 1.0 - initial release
// ============================================================================
module refill_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BLK_WORDS = BLK_WORDS_DEFAULT,
    parameter int CNT_W     = $clog2(BLK_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_wvalid,
    output logic              d_wvalid,
    output logic              i_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  word_idx,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BASE_W = ADDR_W - CNT_W - 2;

    refill_state_t     state;
    refill_state_t     state_next;
    req_id_t           owner;
    req_id_t           last;
    req_id_t           winner;
    logic              start;
    logic [BASE_W-1:0] base;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic              word_accept;
    logic              wvalid_q;

    // Offset bits of the miss addresses are irrelevant: bursts are block aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[CNT_W+1:0], d_addr[CNT_W+1:0]};

    assign word_accept = (state == BURST) && mem_ready;

    block_burst_counter #(
        .BLK_WORDS (BLK_WORDS),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .enable (word_accept),
        .cnt    (cnt),
        .last   (cnt_last)
    );

    // Next state and arbitration. Requests are only looked at in IDLE, so
    // DONE and BURST never react to a request edge.
    always_comb begin
        state_next = state;
        winner     = REQ_I;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    start      = 1'b1;
                    state_next = BURST;
                    if (i_req && d_req) begin
                        winner = (last == REQ_D) ? REQ_I : REQ_D;
                    end else begin
                        winner = i_req ? REQ_I : REQ_D;
                    end
                end
            end
            BURST: begin
                if (mem_ready && cnt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= REQ_I;
            last     <= REQ_D;
            base     <= '0;
            rdata    <= '0;
            word_idx <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state    <= state_next;
            wvalid_q <= word_accept;
            if (start) begin
                owner <= winner;
                base  <= (winner == REQ_I) ? i_addr[ADDR_W-1:CNT_W+2]
                                           : d_addr[ADDR_W-1:CNT_W+2];
            end
            if (word_accept) begin
                rdata    <= mem_rdata;
                word_idx <= cnt;
            end
            if (word_accept && cnt_last) begin
                last <= owner;
            end
        end
    end

    // All memory-side outputs depend only on registered state, never on req.
    assign mem_rd   = (state == BURST);
    assign mem_addr = (state == BURST) ? {base, cnt, 2'b00} : '0;

    assign i_grant  = (state == BURST) && (owner == REQ_I);
    assign d_grant  = (state == BURST) && (owner == REQ_D);

    // The word accepted on the final BURST edge is presented during DONE,
    // so the last wvalid and the done pulse coincide.
    assign i_wvalid = wvalid_q && (owner == REQ_I);
    assign d_wvalid = wvalid_q && (owner == REQ_D);

    assign i_done   = (state == DONE) && (owner == REQ_I);
    assign d_done   = (state == DONE) && (owner == REQ_D);

endmodule
`default_nettype wire

// File: tb/tb_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_refill_arbiter
// Description : Self-checking bench for refill_arbiter. Table of single
//               refills (with stalls and boundary addresses), a word
//               scoreboard filled as requests are issued, and hand-written
//               sequences for arbitration, mid-burst reset and DONE timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_refill_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic        i_grant, d_grant, i_wvalid, d_wvalid, i_done, d_done;
    logic [31:0] rdata;
    logic [1:0]  word_idx;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int words_seen = 0;

    typedef struct {
        logic        is_d;
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_word_t;

    exp_word_t exp_q[$];

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        int          stall_at;
        int          stall_len;
        int          exp_lat;
        logic [31:0] exp_addr0;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    refill_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .i_grant   (i_grant),
        .d_grant   (d_grant),
        .i_wvalid  (i_wvalid),
        .d_wvalid  (d_wvalid),
        .i_done    (i_done),
        .d_done    (d_done),
        .rdata     (rdata),
        .word_idx  (word_idx),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // Memory content: a fixed function of the word address.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_block(input logic is_d, input logic [31:0] addr);
        exp_word_t e;
        for (int k = 0; k < 4; k++) begin
            e.is_d = is_d;
            e.idx  = 2'(k);
            e.data = mem_model({addr[31:4], 4'h0} + 32'(4 * k));
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every delivered word is popped and compared in order.
    always @(negedge clk) begin
        exp_word_t e;
        if (i_wvalid || d_wvalid) begin
            words_seen++;
            if (i_wvalid && d_wvalid) check("wvalid_both", 1, 0);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_owner", d_wvalid, e.is_d);
                check("sb_idx", word_idx, e.idx);
                check("sb_data", rdata, e.data);
            end
        end
        if (i_done) check("i_done_wvalid", i_wvalid, 1);
        if (d_done) check("d_done_wvalid", d_wvalid, 1);
        if (i_grant && d_grant) check("grant_both", 1, 0);
    end

    task automatic do_reset();
        reset     = 1'b1;
        i_req     = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {i_grant, d_grant, i_wvalid, d_wvalid, i_done, d_done, mem_rd, word_idx}, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_maddr"}, mem_addr, 0);
    endtask

    // One refill by one requester; called at a negedge with the DUT in IDLE.
    task automatic run_single(input vec_t v, input string tag);
        int          acc;
        int          done_at;
        logic        ready;
        logic        g;
        logic [31:0] base;
        base    = {v.addr[31:4], 4'h0};
        acc     = 0;
        done_at = -1;
        push_block(v.is_d, v.addr);
        if (v.is_d) begin d_addr = v.addr; d_req = 1'b1; end
        else        begin i_addr = v.addr; i_req = 1'b1; end
        mem_ready = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            g = v.is_d ? d_grant : i_grant;
            if (n == 1) begin
                check({tag, "_grant"}, g, 1);
                check({tag, "_other_grant"}, v.is_d ? i_grant : d_grant, 0);
                check({tag, "_addr0"}, mem_addr, v.exp_addr0);
            end
            if (g) begin
                check({tag, "_maddr"}, mem_addr, base + 32'(4 * acc));
                check({tag, "_mem_rd"}, mem_rd, 1);
            end
            if (v.is_d ? d_done : i_done) begin
                done_at = n;
                check({tag, "_done_mem_rd"}, mem_rd, 0);
                if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
                break;
            end
            ready     = !(n >= v.stall_at && n < v.stall_at + v.stall_len);
            mem_ready = ready;
            if (g && ready) acc++;
        end
        mem_ready = 1'b1;
        check({tag, "_latency"}, done_at, v.exp_lat);
        check({tag, "_accepted"}, acc, 4);
        @(negedge clk);
        check({tag, "_idle_mem_rd"}, mem_rd, 0);
    endtask

    // Holds req until n_blocks done pulses have been seen, then drops it.
    task automatic requester(input logic is_d, input logic [31:0] addr, input int n_blocks);
        int got;
        int guard;
        got   = 0;
        guard = 0;
        if (is_d) begin d_addr = addr; d_req = 1'b1; end
        else      begin i_addr = addr; i_req = 1'b1; end
        while (got < n_blocks && guard < 200) begin
            @(negedge clk);
            guard++;
            if (is_d ? d_done : i_done) begin
                got++;
                if (got == n_blocks) begin
                    if (is_d) d_req = 1'b0; else i_req = 1'b0;
                end
            end
        end
        check(is_d ? "d_blocks" : "i_blocks", got, n_blocks);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int seen0;
        int guard;
        vec_t v;

        //            is_d  addr           stall_at len lat exp_addr0
        vecs[0] = '{1'b0, 32'h0000_1234, 99, 0, 5, 32'h0000_1230};
        vecs[1] = '{1'b1, 32'h8000_00F8,  3, 3, 8, 32'h8000_00F0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 99, 0, 5, 32'hFFFF_FFF0};
        vecs[3] = '{1'b0, 32'h0000_0000,  1, 1, 6, 32'h0000_0000};

        i_addr = '0;
        d_addr = '0;
        do_reset();
        check_all_zero("reset");

        // Table of single refills, each from a fresh reset.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            run_single(vecs[k], $sformatf("v%0d", k));
        end
        check("table_sb_empty", exp_q.size(), 0);

        // Simultaneous requests out of reset: I first, then D.
        do_reset();
        push_block(1'b0, 32'h0000_6000);
        push_block(1'b1, 32'h0000_7000);
        fork
            requester(1'b0, 32'h0000_6000, 1);
            requester(1'b1, 32'h0000_7000, 1);
        join
        @(negedge clk);
        check("tie_sb_empty", exp_q.size(), 0);

        // Both held continuously: I, D, I, D.
        do_reset();
        push_block(1'b0, 32'h0000_A010);
        push_block(1'b1, 32'h0000_B020);
        push_block(1'b0, 32'h0000_A010);
        push_block(1'b1, 32'h0000_B020);
        fork
            requester(1'b0, 32'h0000_A010, 2);
            requester(1'b1, 32'h0000_B020, 2);
        join
        @(negedge clk);
        check("rr_sb_empty", exp_q.size(), 0);

        // Reset after word 1 of a D burst.
        do_reset();
        seen0 = words_seen;
        push_block(1'b1, 32'h0000_4440);
        d_addr = 32'h0000_4440;
        d_req  = 1'b1;
        guard  = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(d_wvalid && word_idx == 2'd1) && guard < 20);
        check("rst_word1_seen", guard < 20, 1);
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b0;
        check("midrst_words", words_seen - seen0, 2);
        exp_q.delete();
        v = '{1'b0, 32'h0000_2000, 99, 0, 5, 32'h0000_2000};
        run_single(v, "after_rst");

        // Request raised in DONE is only granted from the IDLE that follows.
        do_reset();
        push_block(1'b0, 32'h0000_3000);
        push_block(1'b1, 32'h0000_5000);
        i_addr = 32'h0000_3000;
        i_req  = 1'b1;
        guard  = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!i_done && guard < 20);
        check("done_i_seen", i_done, 1);
        i_req  = 1'b0;
        d_addr = 32'h0000_5000;
        d_req  = 1'b1;
        @(negedge clk);
        check("late_req_idle_grant", d_grant, 0);
        check("late_req_idle_mem_rd", mem_rd, 0);
        @(negedge clk);
        check("late_req_grant", d_grant, 1);
        check("late_req_maddr", mem_addr, 32'h0000_5000);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!d_done && guard < 20);
        check("late_req_done", d_done, 1);
        d_req = 1'b0;
        @(negedge clk);
        check("final_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
